// File: rtl/proc_test_sequencer_pkg.sv
// Shared definitions for the test sequencer: state encoding and default bus widths.
package proc_test_sequencer_pkg;

    localparam int DEFAULT_PC_W   = 64;
    localparam int DEFAULT_DATA_W = 64;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CRST   = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6
    } seq_state_e;

endpackage

// File: rtl/proc_test_sequencer_watchdog.sv
// Per-program cycle watchdog: counts enabled cycles, saturates at the limit and flags it.
module run_watchdog #(
    parameter int WDOG_W     = 16,
    parameter int WDOG_LIMIT = 255
) (
    input  logic CLK,
    input  logic resetl,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    logic [WDOG_W-1:0] count;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !hit) begin
            count <= count + WDOG_W'(1);
        end
    end

    assign hit = (count == WDOG_W'(WDOG_LIMIT));

endmodule

// File: rtl/proc_test_sequencer.sv
// Run controller: resets the core at each slot's start PC, runs it to its end PC,
// compares the settled dmemout against the slot's pass code and tallies the results.
module proc_test_sequencer
    import proc_test_sequencer_pkg::*;
#(
    parameter int NUM_PROGS  = 2,
    parameter int PC_W       = DEFAULT_PC_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int RST_CYCLES = 1,
    parameter int WDOG_W     = 16,
    parameter int WDOG_LIMIT = 255,
    localparam int CNT_W     = $clog2(NUM_PROGS + 1)
) (
    input  logic                        CLK,
    input  logic                        resetl,
    input  logic                        start,
    input  logic [NUM_PROGS*PC_W-1:0]   prog_start_pc,
    input  logic [NUM_PROGS*PC_W-1:0]   prog_end_pc,
    input  logic [NUM_PROGS*DATA_W-1:0] prog_expect,
    input  logic [PC_W-1:0]             currentpc,
    input  logic [DATA_W-1:0]           dmemout,
    output logic                        proc_resetl,
    output logic [PC_W-1:0]             proc_startpc,
    output logic                        busy,
    output logic                        done,
    output logic                        all_passed,
    output logic [CNT_W-1:0]            pass_count,
    output logic [NUM_PROGS-1:0]        fail_mask,
    output logic [NUM_PROGS-1:0]        timeout_mask
);

    localparam int IDX_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    seq_state_e        state, state_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [RST_W-1:0]  rst_cnt;
    logic              clear_results;
    logic              wdog_hit;
    logic              end_reached;
    logic [PC_W-1:0]   cur_end_pc;
    logic [DATA_W-1:0] cur_expect;

    assign cur_end_pc  = prog_end_pc[idx*PC_W +: PC_W];
    assign cur_expect  = prog_expect[idx*DATA_W +: DATA_W];
    assign end_reached = (currentpc >= cur_end_pc);

    run_watchdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_watchdog (
        .CLK    (CLK),
        .resetl (resetl),
        .clear  (state == S_CRST),
        .enable (state == S_RUN),
        .hit    (wdog_hit)
    );

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        clear_results = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next    = S_CRST;
                    idx_next      = '0;
                    clear_results = 1'b1;
                end
            end
            S_CRST: begin
                if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                    state_next = S_RUN;
                end
            end
            // Reaching the end PC takes priority over a watchdog hit in the same cycle.
            S_RUN: begin
                if (end_reached) begin
                    state_next = S_SETTLE;
                end else if (wdog_hit) begin
                    state_next = S_NEXT;
                end
            end
            S_SETTLE: state_next = S_CHECK;
            S_CHECK:  state_next = S_NEXT;
            S_NEXT: begin
                if (idx == IDX_W'(NUM_PROGS - 1)) begin
                    state_next = S_DONE;
                end else begin
                    idx_next   = idx + IDX_W'(1);
                    state_next = S_CRST;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            idx          <= '0;
            rst_cnt      <= '0;
            proc_resetl  <= 1'b0;
            proc_startpc <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            all_passed   <= 1'b0;
            pass_count   <= '0;
            fail_mask    <= '0;
            timeout_mask <= '0;
        end else begin
            idx         <= idx_next;
            proc_resetl <= (state_next == S_RUN) || (state_next == S_SETTLE);
            busy        <= (state_next != S_IDLE) && (state_next != S_DONE);
            done        <= (state_next == S_DONE);
            all_passed  <= (state_next == S_DONE) && (pass_count == CNT_W'(NUM_PROGS));

            if ((state_next == S_CRST) && (state != S_CRST)) begin
                proc_startpc <= prog_start_pc[idx_next*PC_W +: PC_W];
                rst_cnt      <= '0;
            end else if (state == S_CRST) begin
                rst_cnt <= rst_cnt + RST_W'(1);
            end

            if (clear_results) begin
                pass_count   <= '0;
                fail_mask    <= '0;
                timeout_mask <= '0;
            end

            if ((state == S_RUN) && !end_reached && wdog_hit) begin
                fail_mask[idx]    <= 1'b1;
                timeout_mask[idx] <= 1'b1;
            end

            if (state == S_CHECK) begin
                if (dmemout == cur_expect) begin
                    if (pass_count != CNT_W'(NUM_PROGS)) begin
                        pass_count <= pass_count + CNT_W'(1);
                    end
                end else begin
                    fail_mask[idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Scoreboard bench for proc_test_sequencer driving a behavioural core (PC += 4 per cycle).
module tb_proc_test_sequencer;

    localparam int N     = 2;
    localparam int PC_W  = 64;
    localparam int DW    = 64;
    localparam int CNT_W = 2;

    logic            CLK = 1'b0;
    logic            resetl;
    logic            start;
    logic [N*PC_W-1:0] prog_start_pc, prog_end_pc;
    logic [N*DW-1:0] prog_expect;
    logic [PC_W-1:0] currentpc;
    logic [DW-1:0]   dmemout;
    logic            proc_resetl;
    logic [PC_W-1:0] proc_startpc;
    logic            busy, done, all_passed;
    logic [CNT_W-1:0] pass_count;
    logic [N-1:0]    fail_mask, timeout_mask;

    logic [PC_W-1:0] cfg_start  [N];
    logic [PC_W-1:0] cfg_end    [N];
    logic [DW-1:0]   cfg_code   [N];
    logic [DW-1:0]   cfg_expect [N];
    logic            cfg_freeze [N];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [CNT_W-1:0] pass_count;
        logic [N-1:0]     fail_mask;
        logic [N-1:0]     timeout_mask;
        logic             all_passed;
    } exp_t;

    typedef struct {
        logic [PC_W-1:0] startpc;
        int              high;
    } slot_exp_t;

    exp_t      exp_q[$];
    slot_exp_t slot_q[$];

    assign prog_start_pc = {cfg_start[1], cfg_start[0]};
    assign prog_end_pc   = {cfg_end[1], cfg_end[0]};
    assign prog_expect   = {cfg_expect[1], cfg_expect[0]};

    always #5 CLK = ~CLK;

    proc_test_sequencer dut (
        .CLK           (CLK),
        .resetl        (resetl),
        .start         (start),
        .prog_start_pc (prog_start_pc),
        .prog_end_pc   (prog_end_pc),
        .prog_expect   (prog_expect),
        .currentpc     (currentpc),
        .dmemout       (dmemout),
        .proc_resetl   (proc_resetl),
        .proc_startpc  (proc_startpc),
        .busy          (busy),
        .done          (done),
        .all_passed    (all_passed),
        .pass_count    (pass_count),
        .fail_mask     (fail_mask),
        .timeout_mask  (timeout_mask)
    );

    // Behavioural core: slot chosen by its start PC, dmemout lands one cycle after the end PC.
    logic msel;
    assign msel = (proc_startpc == cfg_start[1]);

    always_ff @(posedge CLK) begin
        if (!proc_resetl) begin
            currentpc <= proc_startpc;
            dmemout   <= '0;
        end else begin
            if (!cfg_freeze[msel]) currentpc <= currentpc + 64'd4;
            dmemout <= (currentpc >= cfg_end[msel]) ? cfg_code[msel] : '0;
        end
    end

    task automatic set_slot(input int i, input logic [PC_W-1:0] s, input logic [PC_W-1:0] e,
                            input logic [DW-1:0] code, input logic [DW-1:0] expv, input logic frz);
        cfg_start[i]  = s;
        cfg_end[i]    = e;
        cfg_code[i]   = code;
        cfg_expect[i] = expv;
        cfg_freeze[i] = frz;
    endtask

    task automatic push_expected();
        exp_t      e;
        slot_exp_t s;
        e.pass_count   = '0;
        e.fail_mask    = '0;
        e.timeout_mask = '0;
        for (int i = 0; i < N; i++) begin
            s.startpc = cfg_start[i];
            if (cfg_freeze[i] && (cfg_end[i] > cfg_start[i])) begin
                s.high            = -1;
                e.fail_mask[i]    = 1'b1;
                e.timeout_mask[i] = 1'b1;
            end else begin
                if (cfg_end[i] <= cfg_start[i]) s.high = 2;
                else s.high = int'((cfg_end[i] - cfg_start[i] + 64'd3) >> 2) + 2;
                if (cfg_code[i] == cfg_expect[i]) e.pass_count = e.pass_count + 2'd1;
                else e.fail_mask[i] = 1'b1;
            end
            slot_q.push_back(s);
        end
        e.all_passed = (e.pass_count == CNT_W'(N));
        exp_q.push_back(e);
    endtask

    task automatic run_sequence(input string name, input bit poke_start);
        exp_t      e;
        slot_exp_t s;
        int        high_cnt;
        bit        prev_high;
        bit        finished;
        push_expected();
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
        high_cnt  = 0;
        prev_high = 1'b0;
        finished  = 1'b0;
        s.startpc = '0;
        s.high    = -1;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (cyc == 0) begin
                total++;
                if (busy !== 1'b1 || done !== 1'b0 || proc_resetl !== 1'b0 || pass_count !== '0
                    || fail_mask !== '0 || timeout_mask !== '0) begin
                    bad++;
                    $display("[TB] FAIL %s start_clear: busy=%b done=%b prst=%b pc=%0d fm=%b tm=%b expected 1 0 0 0 00 00",
                             name, busy, done, proc_resetl, pass_count, fail_mask, timeout_mask);
                end
            end
            start = poke_start && (cyc == 6 || cyc == 7);
            if (proc_resetl && !prev_high) begin
                high_cnt = 0;
                total++;
                if (slot_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL %s extra_run: got startpc %0h expected no run", name, proc_startpc);
                end else begin
                    s = slot_q.pop_front();
                    if (proc_startpc !== s.startpc) begin
                        bad++;
                        $display("[TB] FAIL %s startpc: got %0h expected %0h", name, proc_startpc, s.startpc);
                    end
                end
            end
            if (proc_resetl) high_cnt++;
            else if (prev_high && s.high >= 0) begin
                total++;
                if (high_cnt != s.high) begin
                    bad++;
                    $display("[TB] FAIL %s run_length: got %0d expected %0d", name, high_cnt, s.high);
                end
            end
            if (done) finished = 1'b1;
            prev_high = proc_resetl;
            if (!finished) @(negedge CLK);
        end
        start = 1'b0;
        total++;
        if (!finished) begin
            bad++;
            $display("[TB] FAIL %s done_timeout: got done=%b expected 1", name, done);
        end
        total++;
        if (slot_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s slots_run: got %0d missing expected 0", name, slot_q.size());
            slot_q.delete();
        end
        e = exp_q.pop_front();
        total++;
        if (pass_count !== e.pass_count || fail_mask !== e.fail_mask || timeout_mask !== e.timeout_mask
            || all_passed !== e.all_passed || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s results: got pc=%0d fm=%b tm=%b ap=%b busy=%b expected pc=%0d fm=%b tm=%b ap=%b busy=0",
                     name, pass_count, fail_mask, timeout_mask, all_passed, busy,
                     e.pass_count, e.fail_mask, e.timeout_mask, e.all_passed);
        end
    endtask

    task automatic test_reset();
        resetl = 1'b0;
        start  = 1'b0;
        #1;
        total++;
        if (proc_resetl !== 1'b0 || proc_startpc !== '0 || busy !== 1'b0 || done !== 1'b0
            || all_passed !== 1'b0 || pass_count !== '0 || fail_mask !== '0 || timeout_mask !== '0) begin
            bad++;
            $display("[TB] FAIL reset_state: got prst=%b spc=%0h busy=%b done=%b ap=%b pc=%0d fm=%b tm=%b expected all zero",
                     proc_resetl, proc_startpc, busy, done, all_passed, pass_count, fail_mask, timeout_mask);
        end
        repeat (3) @(negedge CLK);
        resetl = 1'b1;
        @(negedge CLK);
        total++;
        if (proc_resetl !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_hold: got prst=%b busy=%b expected 0 0", proc_resetl, busy);
        end
    endtask

    task automatic test_all_pass();
        set_slot(0, 64'h0,  64'h34, 64'hF, 64'hF, 1'b0);
        set_slot(1, 64'h40, 64'h54, 64'hB, 64'hB, 1'b0);
        run_sequence("all_pass", 1'b0);
    endtask

    task automatic test_mismatch();
        set_slot(1, 64'h40, 64'h54, 64'hA, 64'hB, 1'b0);
        run_sequence("mismatch", 1'b0);
    endtask

    task automatic test_timeout();
        set_slot(0, 64'h10, 64'h34, 64'hF, 64'hF, 1'b1);
        set_slot(1, 64'h40, 64'h54, 64'hB, 64'hB, 1'b0);
        run_sequence("timeout", 1'b0);
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        set_slot(0, 64'h0,  64'h34, 64'hF, 64'hF, 1'b0);
        set_slot(1, 64'h40, 64'h54, 64'hB, 64'hB, 1'b0);
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            if (proc_resetl && proc_startpc == cfg_start[1]) seen = 1'b1;
            else @(negedge CLK);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL midrun_reach: got no slot1 run expected slot1 running");
        end
        @(negedge CLK);
        #1 resetl = 1'b0;
        #1;
        total++;
        if (proc_resetl !== 1'b0 || proc_startpc !== '0 || busy !== 1'b0 || done !== 1'b0
            || all_passed !== 1'b0 || pass_count !== '0 || fail_mask !== '0 || timeout_mask !== '0) begin
            bad++;
            $display("[TB] FAIL midrun_reset: got prst=%b spc=%0h busy=%b done=%b ap=%b pc=%0d fm=%b tm=%b expected all zero",
                     proc_resetl, proc_startpc, busy, done, all_passed, pass_count, fail_mask, timeout_mask);
        end
        repeat (2) @(negedge CLK);
        resetl = 1'b1;
        run_sequence("rerun_after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        set_slot(0, 64'h0,  64'h34, 64'hF, 64'hF, 1'b0);
        set_slot(1, 64'h40, 64'h54, 64'hA, 64'hB, 1'b0);
        run_sequence("start_while_busy", 1'b1);
        set_slot(1, 64'h40, 64'h54, 64'hB, 64'hB, 1'b0);
        run_sequence("restart_from_done", 1'b0);
    endtask

    task automatic test_zero_length();
        set_slot(0, 64'h40, 64'h40, 64'h5, 64'h5, 1'b0);
        set_slot(1, 64'h80, 64'h80, 64'h6, 64'h6, 1'b0);
        run_sequence("zero_length", 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_slot(i, '0, '0, '0, '0, 1'b0);
        test_reset();
        test_all_pass();
        test_mismatch();
        test_timeout();
        test_reset_mid_run();
        test_back_to_back();
        test_zero_length();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
